// File: rtl/ie_mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// ie_mem_lsu_pkg
// Shared pipeline definitions for the execute-to-memory load/store unit:
//   - write-back source select encoding (wb_sel_e)
//   - load width/sign select encoding (load_sel_e)
//   - store width select encoding (store_sel_e)
//   - memory-stage access FSM states (lsu_state_e)
//   - isMisaligned() helper shared by the E-side lookahead and the M-side flag
// -----------------------------------------------------------------------------
package ie_mem_lsu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC   = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_sel_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_sel_e;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_ACCESS = 1'b1
    } lsu_state_e;

    // Byte accesses can never be misaligned. Halfword accesses need an even
    // address. Everything else, including the unused encodings that fall back
    // to word behaviour, needs a word-aligned address.
    function automatic logic isMisaligned(input logic       isStore,
                                          input logic [1:0] storeSel,
                                          input logic [2:0] loadSel,
                                          input logic [1:0] offset);
        logic isByte;
        logic isHalf;
        if (isStore) begin
            isByte = (storeSel == ST_SB);
            isHalf = (storeSel == ST_SH);
        end else begin
            isByte = (loadSel == LD_LB) || (loadSel == LD_LBU);
            isHalf = (loadSel == LD_LH) || (loadSel == LD_LHU);
        end
        if (isByte)      return 1'b0;
        else if (isHalf) return offset[0];
        else             return (offset != 2'b00);
    endfunction

endpackage

// File: rtl/ie_mem_lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational extraction of load data from a 32-bit memory word.
// Ports:
//   rdata_i    - raw word returned by data memory
//   offset_i   - byte offset within the word (address bits [1:0])
//   load_sel_i - load width/sign select (unused codes act as LW)
//   enable_i   - high when the M-stage instruction is a load
//   data_o     - aligned, sign/zero-extended result (0 when not enabled)
// -----------------------------------------------------------------------------
module lsu_load_align
    import ie_mem_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_sel_i,
    input  logic        enable_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Pick the addressed byte and halfword lanes, then extend according to the
    // load type. Halfword selection only looks at offset[1] because odd
    // halfword addresses are rejected as misaligned before data is consumed.
    always_comb begin
        byteVal = rdata_i[7:0];
        halfVal = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (offset_i)
            2'd0:    byteVal = rdata_i[7:0];
            2'd1:    byteVal = rdata_i[15:8];
            2'd2:    byteVal = rdata_i[23:16];
            default: byteVal = rdata_i[31:24];
        endcase

        data_o = '0;
        if (enable_i) begin
            case (load_sel_i)
                LD_LB:   data_o = {{24{byteVal[7]}}, byteVal};
                LD_LH:   data_o = {{16{halfVal[15]}}, halfVal};
                LD_LBU:  data_o = {24'd0, byteVal};
                LD_LHU:  data_o = {16'd0, halfVal};
                default: data_o = rdata_i;
            endcase
        end
    end

endmodule

// File: rtl/ie_mem_lsu.sv
// -----------------------------------------------------------------------------
// ie_mem_lsu
// Execute/memory pipeline register plus load/store unit for the M stage.
// Ports:
//   i_clk, i_rst          - clock and synchronous active-high reset
//   *E inputs             - execute-stage control/data captured into M
//   o_dmem_*              - data-memory request (addr word aligned, byte mask)
//   i_dmem_ack/rdata      - data-memory handshake and read data
//   *M outputs            - memory-stage values handed to write-back
//   stallM                - freezes earlier stages while a request is pending
//   o_misalignM           - M-stage instruction is a misaligned memory op
// -----------------------------------------------------------------------------
module ie_mem_lsu
    import ie_mem_lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        rd_wrenE,
    input  logic [1:0]  wb_selE,
    input  logic        mem_wrenE,
    input  logic [2:0]  load_selE,
    input  logic [1:0]  store_selE,
    input  logic [31:0] alu_resultE,
    input  logic [31:0] store_dataE,
    input  logic [4:0]  rdE,
    input  logic [31:0] pc_nxtE,
    input  logic        insn_vldE,

    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,

    output logic        rd_wrenM,
    output logic [1:0]  wb_selM,
    output logic [31:0] alu_resultM,
    output logic [31:0] ld_dataM,
    output logic [4:0]  rdM,
    output logic [31:0] pc_nxtM,
    output logic        insn_vldM,
    output logic        stallM,
    output logic        o_misalignM
);

    lsu_state_e  state_q, state_d;

    logic        rdWren_q;
    logic [1:0]  wbSel_q;
    logic        memWren_q;
    logic [2:0]  loadSel_q;
    logic [1:0]  storeSel_q;
    logic [31:0] aluResult_q;
    logic [31:0] storeData_q;
    logic [4:0]  rd_q;
    logic [31:0] pcNxt_q;
    logic        insnVld_q;

    logic        memOpM;
    logic        misalignM;
    logic        isLoadM;
    logic        memOpE;
    logic        accessE;

    // Memory-op classification for the held instruction and a lookahead on
    // the incoming one, so the FSM can enter ACCESS in the same edge that
    // captures an aligned memory op.
    always_comb begin
        memOpM    = insnVld_q && (memWren_q || (wbSel_q == WB_LOAD));
        misalignM = memOpM && isMisaligned(memWren_q, storeSel_q, loadSel_q,
                                           aluResult_q[1:0]);
        isLoadM   = insnVld_q && (wbSel_q == WB_LOAD);
        memOpE    = insnVld_q == insnVld_q && insn_vldE &&
                    (mem_wrenE || (wb_selE == WB_LOAD));
        accessE   = memOpE && !isMisaligned(mem_wrenE, store_selE, load_selE,
                                            alu_resultE[1:0]);
    end

    // The stall is combinational on ack so a zero-wait access costs no extra
    // cycle: the ack cycle itself lets the next instruction in.
    assign stallM = (state_q == LSU_ACCESS) && !i_dmem_ack;

    // Next-state: while stalled we stay put; otherwise the state follows
    // whatever is being captured this edge. An ack seen in IDLE has no effect
    // because stallM is already low there.
    always_comb begin
        state_d = state_q;
        if (!stallM) begin
            state_d = accessE ? LSU_ACCESS : LSU_IDLE;
        end
    end

    // FSM state register. Reset abandons any outstanding request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // E->M pipeline register: captures every unstalled edge, holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdWren_q    <= 1'b0;
            wbSel_q     <= 2'b00;
            memWren_q   <= 1'b0;
            loadSel_q   <= 3'b000;
            storeSel_q  <= 2'b00;
            aluResult_q <= '0;
            storeData_q <= '0;
            rd_q        <= '0;
            pcNxt_q     <= '0;
            insnVld_q   <= 1'b0;
        end else if (!stallM) begin
            rdWren_q    <= rd_wrenE;
            wbSel_q     <= wb_selE;
            memWren_q   <= mem_wrenE;
            loadSel_q   <= load_selE;
            storeSel_q  <= store_selE;
            aluResult_q <= alu_resultE;
            storeData_q <= store_dataE;
            rd_q        <= rdE;
            pcNxt_q     <= pc_nxtE;
            insnVld_q   <= insn_vldE;
        end
    end

    // Store lane steering: data is replicated across lanes so the byte mask
    // alone picks the destination. Loads and SW use the full mask.
    always_comb begin
        o_dmem_bmask = 4'b1111;
        o_dmem_wdata = storeData_q;
        if (memWren_q) begin
            case (storeSel_q)
                ST_SB: begin
                    o_dmem_bmask = 4'b0001 << aluResult_q[1:0];
                    o_dmem_wdata = {4{storeData_q[7:0]}};
                end
                ST_SH: begin
                    o_dmem_bmask = 4'b0011 << aluResult_q[1:0];
                    o_dmem_wdata = {2{storeData_q[15:0]}};
                end
                default: begin
                    o_dmem_bmask = 4'b1111;
                    o_dmem_wdata = storeData_q;
                end
            endcase
        end
    end

    assign o_dmem_req  = (state_q == LSU_ACCESS);
    assign o_dmem_we   = memWren_q;
    assign o_dmem_addr = {aluResult_q[31:2], 2'b00};

    lsu_load_align uLoadAlign (
        .rdata_i    (i_dmem_rdata),
        .offset_i   (aluResult_q[1:0]),
        .load_sel_i (loadSel_q),
        .enable_i   (isLoadM),
        .data_o     (ld_dataM)
    );

    // A misaligned op never writes the register file.
    assign rd_wrenM    = rdWren_q && !misalignM;
    assign o_misalignM = misalignM;
    assign wb_selM     = wbSel_q;
    assign alu_resultM = aluResult_q;
    assign rdM         = rd_q;
    assign pc_nxtM     = pcNxt_q;
    assign insn_vldM   = insnVld_q;

endmodule

// File: tb/tb_ie_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_ie_mem_lsu
// Directed bench for ie_mem_lsu: a linear sequence of execute-stage vectors
// with hand-computed memory-stage and data-memory expectations.
// -----------------------------------------------------------------------------
module tb_ie_mem_lsu;

    logic        i_clk;
    logic        i_rst;
    logic        rd_wrenE;
    logic [1:0]  wb_selE;
    logic        mem_wrenE;
    logic [2:0]  load_selE;
    logic [1:0]  store_selE;
    logic [31:0] alu_resultE;
    logic [31:0] store_dataE;
    logic [4:0]  rdE;
    logic [31:0] pc_nxtE;
    logic        insn_vldE;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_bmask;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        rd_wrenM;
    logic [1:0]  wb_selM;
    logic [31:0] alu_resultM;
    logic [31:0] ld_dataM;
    logic [4:0]  rdM;
    logic [31:0] pc_nxtM;
    logic        insn_vldM;
    logic        stallM;
    logic        o_misalignM;

    int checks;
    int errors;

    ie_mem_lsu dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .rd_wrenE     (rd_wrenE),
        .wb_selE      (wb_selE),
        .mem_wrenE    (mem_wrenE),
        .load_selE    (load_selE),
        .store_selE   (store_selE),
        .alu_resultE  (alu_resultE),
        .store_dataE  (store_dataE),
        .rdE          (rdE),
        .pc_nxtE      (pc_nxtE),
        .insn_vldE    (insn_vldE),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_bmask (o_dmem_bmask),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .rd_wrenM     (rd_wrenM),
        .wb_selM      (wb_selM),
        .alu_resultM  (alu_resultM),
        .ld_dataM     (ld_dataM),
        .rdM          (rdM),
        .pc_nxtM      (pc_nxtM),
        .insn_vldM    (insn_vldM),
        .stallM       (stallM),
        .o_misalignM  (o_misalignM)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Step to just after the next rising edge so registered state is settled.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one execute-stage instruction.
    task automatic applyStimulus(input logic        vld,
                                 input logic        rdWren,
                                 input logic [1:0]  wbSel,
                                 input logic        memWren,
                                 input logic [2:0]  loadSel,
                                 input logic [1:0]  storeSel,
                                 input logic [31:0] alu,
                                 input logic [31:0] sdata,
                                 input logic [4:0]  rd,
                                 input logic [31:0] pcNxt);
        insn_vldE   = vld;
        rd_wrenE    = rdWren;
        wb_selE     = wbSel;
        mem_wrenE   = memWren;
        load_selE   = loadSel;
        store_selE  = storeSel;
        alu_resultE = alu;
        store_dataE = sdata;
        rdE         = rd;
        pc_nxtE     = pcNxt;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst = 1'b1;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = 32'h0;
        applyBubble();

        // Reset state
        tick();
        tick();
        checkOutput("rst_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("rst_stall", {31'd0, stallM}, 32'd0);
        checkOutput("rst_misalign", {31'd0, o_misalignM}, 32'd0);
        checkOutput("rst_vld", {31'd0, insn_vldM}, 32'd0);
        checkOutput("rst_rdwren", {31'd0, rd_wrenM}, 32'd0);
        checkOutput("rst_alu", alu_resultM, 32'd0);
        i_rst = 1'b0;

        // ALU op passes straight through
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'b010, 2'b10, 32'h1234, 32'h0, 5'd5, 32'h44);
        tick();
        applyBubble();
        #1;
        checkOutput("alu_result", alu_resultM, 32'h1234);
        checkOutput("alu_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("alu_stall", {31'd0, stallM}, 32'd0);
        checkOutput("alu_rd", {27'd0, rdM}, 32'd5);
        checkOutput("alu_rdwren", {31'd0, rd_wrenM}, 32'd1);
        checkOutput("alu_pcnxt", pc_nxtM, 32'h44);

        // LB at 0x103 with two wait states
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 5'd7, 32'h48);
        tick();
        applyBubble();
        i_dmem_rdata = 32'h80FF_7F01;
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("lb_req", {31'd0, o_dmem_req}, 32'd1);
        checkOutput("lb_stall_w1", {31'd0, stallM}, 32'd1);
        checkOutput("lb_addr", o_dmem_addr, 32'h100);
        checkOutput("lb_bmask", {28'd0, o_dmem_bmask}, 32'hF);
        checkOutput("lb_we", {31'd0, o_dmem_we}, 32'd0);
        tick();
        checkOutput("lb_stall_w2", {31'd0, stallM}, 32'd1);
        checkOutput("lb_hold_alu", alu_resultM, 32'h103);
        checkOutput("lb_hold_addr", o_dmem_addr, 32'h100);
        tick();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("lb_ack_stall", {31'd0, stallM}, 32'd0);
        checkOutput("lb_data", ld_dataM, 32'hFFFF_FF80);
        checkOutput("lb_wbsel", {30'd0, wb_selM}, 32'd1);
        tick();
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("lb_done_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("lb_done_ld0", ld_dataM, 32'd0);

        // LBU at 0x103, zero wait
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b100, 2'b00, 32'h103, 32'h0, 5'd7, 32'h4C);
        tick();
        applyBubble();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("lbu_stall", {31'd0, stallM}, 32'd0);
        checkOutput("lbu_data", ld_dataM, 32'h0000_0080);
        tick();
        i_dmem_ack = 1'b0;

        // LH / LHU at 0x102, zero wait
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 5'd8, 32'h50);
        tick();
        applyBubble();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("lh_data", ld_dataM, 32'hFFFF_80FF);
        checkOutput("lh_misalign", {31'd0, o_misalignM}, 32'd0);
        tick();
        i_dmem_ack = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b101, 2'b00, 32'h100, 32'h0, 5'd8, 32'h54);
        tick();
        applyBubble();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("lhu_data", ld_dataM, 32'h0000_7F01);
        tick();
        i_dmem_ack = 1'b0;

        // SH 0xABCD at 0x202, zero wait
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 2'b01, 32'h202, 32'h1234_ABCD, 5'd0, 32'h58);
        tick();
        applyBubble();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("sh_req", {31'd0, o_dmem_req}, 32'd1);
        checkOutput("sh_bmask", {28'd0, o_dmem_bmask}, 32'hC);
        checkOutput("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
        checkOutput("sh_we", {31'd0, o_dmem_we}, 32'd1);
        checkOutput("sh_addr", o_dmem_addr, 32'h200);
        checkOutput("sh_stall", {31'd0, stallM}, 32'd0);
        tick();
        i_dmem_ack = 1'b0;

        // SB 0x5A at 0x301, zero wait
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 2'b00, 32'h301, 32'h0000_005A, 5'd0, 32'h5C);
        tick();
        applyBubble();
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("sb_bmask", {28'd0, o_dmem_bmask}, 32'h2);
        checkOutput("sb_wdata", o_dmem_wdata, 32'h5A5A_5A5A);
        tick();
        i_dmem_ack = 1'b0;

        // Misaligned LW at 0x101
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 2'b00, 32'h101, 32'h0, 5'd9, 32'h60);
        tick();
        applyBubble();
        #1;
        checkOutput("mis_flag", {31'd0, o_misalignM}, 32'd1);
        checkOutput("mis_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("mis_rdwren", {31'd0, rd_wrenM}, 32'd0);
        checkOutput("mis_stall", {31'd0, stallM}, 32'd0);
        tick();
        checkOutput("mis_clear", {31'd0, o_misalignM}, 32'd0);

        // Back-to-back LW 0x40 then SW 0x44, each zero wait
        i_dmem_rdata = 32'hCAFE_F00D;
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 2'b00, 32'h40, 32'h0, 5'd10, 32'h64);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 3'b000, 2'b10, 32'h44, 32'hDEAD_BEEF, 5'd0, 32'h68);
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("b2b_lw_req", {31'd0, o_dmem_req}, 32'd1);
        checkOutput("b2b_lw_addr", o_dmem_addr, 32'h40);
        checkOutput("b2b_lw_data", ld_dataM, 32'hCAFE_F00D);
        checkOutput("b2b_lw_stall", {31'd0, stallM}, 32'd0);
        tick();
        applyBubble();
        #1;
        checkOutput("b2b_sw_req", {31'd0, o_dmem_req}, 32'd1);
        checkOutput("b2b_sw_we", {31'd0, o_dmem_we}, 32'd1);
        checkOutput("b2b_sw_addr", o_dmem_addr, 32'h44);
        checkOutput("b2b_sw_wdata", o_dmem_wdata, 32'hDEAD_BEEF);
        checkOutput("b2b_sw_bmask", {28'd0, o_dmem_bmask}, 32'hF);
        tick();
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("b2b_idle_req", {31'd0, o_dmem_req}, 32'd0);

        // Ack while IDLE is ignored
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("idle_ack_stall", {31'd0, stallM}, 32'd0);
        tick();
        checkOutput("idle_ack_req", {31'd0, o_dmem_req}, 32'd0);
        i_dmem_ack = 1'b0;

        // Reset during ACCESS, ack arrives one cycle later
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 2'b00, 32'h50, 32'h0, 5'd11, 32'h6C);
        tick();
        applyBubble();
        #1;
        checkOutput("rsta_req_pre", {31'd0, o_dmem_req}, 32'd1);
        checkOutput("rsta_stall_pre", {31'd0, stallM}, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_dmem_ack = 1'b1;
        #1;
        checkOutput("rsta_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("rsta_stall", {31'd0, stallM}, 32'd0);
        checkOutput("rsta_vld", {31'd0, insn_vldM}, 32'd0);
        checkOutput("rsta_alu", alu_resultM, 32'd0);
        checkOutput("rsta_ld", ld_dataM, 32'd0);
        checkOutput("rsta_rdwren", {31'd0, rd_wrenM}, 32'd0);
        tick();
        i_dmem_ack = 1'b0;
        #1;
        checkOutput("rsta_after_req", {31'd0, o_dmem_req}, 32'd0);
        checkOutput("rsta_after_mis", {31'd0, o_misalignM}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
